sdp_ram_rd_arb: RTL and testbench

//  Controller for one simple dual-port block RAM instance (write port A, registered read port B).
//  - Clears the whole array after reset or on request.
//  - Accepts one write stream.
//  - Shares read port B round-robin between NR read requesters, with latency-matched responses.
//  - Sits between client logic and the RAM wrapper; drives every RAM pin.

---
 rtl/sdp_ram_rd_arb_pkg.sv | 18 +
 rtl/sdp_ram_rd_arb_rr_arb.sv | 47 ++++
 rtl/sdp_ram_rd_arb.sv | 115 +++++++++++
 tb/tb_sdp_ram_rd_arb.sv | 418 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdp_ram_rd_arb_pkg.sv
// Shared constants for the simple dual-port RAM read-arbitration controller:
// FSM state codes and helpers for the read latency and index widths.
package sdp_ram_rd_arb_pkg;

    localparam logic [1:0] ST_CLR   = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    // Read latency of port B: one cycle for the array read, one more with the output register.
    function automatic int read_latency(input bit out_reg);
        return out_reg ? 2 : 1;
    endfunction

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sdp_ram_rd_arb_rr_arb.sv
// NR-way round-robin arbiter: the search starts just after the last winner;
// the pointer moves only when a grant is issued.
module sdp_ram_rd_arb_rr_arb
    import sdp_ram_rd_arb_pkg::*;
#(
    parameter  int NR = 2,
    localparam int IW = idx_width(NR)
) (
    input  logic          Ck,
    input  logic          Rst_N,
    input  logic          en,
    input  logic [NR-1:0] req,
    output logic [NR-1:0] gnt,
    output logic          gnt_vld,
    output logic [IW-1:0] gnt_idx
);

    logic [IW-1:0] ptr;

    always_comb begin
        int            c;
        logic [IW-1:0] ci;
        // NOTE: every output gets a default first, so no path through the block infers a latch.
        gnt     = '0;
        gnt_vld = 1'b0;
        gnt_idx = '0;
        c       = 0;
        ci      = '0;
        // Scan farthest candidate first so the nearest requester after ptr wins the last write.
        for (int k = NR; k >= 1; k--) begin
            c = int'(ptr) + k;
            if (c >= NR) c = c - NR;
            ci = c[IW-1:0];
            if (en && req[ci]) begin
                gnt_vld = 1'b1;
                gnt_idx = ci;
            end
        end
        if (gnt_vld) gnt[gnt_idx] = 1'b1;
    end

    always_ff @(posedge Ck) begin
        if (!Rst_N)       ptr <= IW'(NR - 1);
        else if (gnt_vld) ptr <= gnt_idx;
    end

endmodule

// File: rtl/sdp_ram_rd_arb.sv
// Controller for one simple dual-port block RAM: array clear, one write stream,
// and round-robin sharing of the registered read port with latency-matched responses.
module sdp_ram_rd_arb
    import sdp_ram_rd_arb_pkg::*;
#(
    parameter int    AW      = 4,
    parameter int    DW      = 8,
    parameter int    NR      = 2,
    parameter string OR      = "TRUE",
    parameter bit    CLR_RST = 1'b1
) (
    input  logic             Ck,
    input  logic             Rst_N,
    input  logic             Clr_Req,
    output logic             Clr_Busy,
    input  logic             Wr_Vld,
    output logic             Wr_Rdy,
    input  logic [AW-1:0]    Wr_Ad,
    input  logic [DW-1:0]    Wr_D,
    input  logic [NR-1:0]    Rq_Vld,
    output logic [NR-1:0]    Rq_Rdy,
    input  logic [NR*AW-1:0] Rq_Ad,
    output logic [NR-1:0]    Rs_Vld,
    output logic [DW-1:0]    Rs_D,
    output logic             A_CE,
    output logic             A_WE,
    output logic [AW-1:0]    A_Ad,
    output logic [DW-1:0]    A_WD,
    output logic             B_CE,
    output logic [AW-1:0]    B_Ad,
    input  logic [DW-1:0]    B_RD
);

    localparam int RL = read_latency(OR == "TRUE");
    localparam int IW = idx_width(NR);

    logic [1:0]    state;
    logic [AW-1:0] clr_cnt;
    logic          run;
    logic          arb_vld;
    logic [IW-1:0] arb_idx;
    logic [NR-1:0] arb_gnt;
    logic [RL-1:0] tag_vld;
    logic [IW-1:0] tag_idx [RL];

    // Every output is forced low while reset is asserted, including the combinational ones.
    assign run      = Rst_N && (state == ST_RUN);
    assign Clr_Busy = Rst_N && (state != ST_RUN);
    assign Wr_Rdy   = run;
    assign Rq_Rdy   = arb_gnt;
    assign B_CE     = Rst_N;
    assign B_Ad     = arb_vld ? Rq_Ad[arb_idx*AW +: AW] : '0;
    assign Rs_Vld   = (Rst_N && tag_vld[RL-1]) ? (NR'(1) << tag_idx[RL-1]) : '0;
    assign Rs_D     = (Rst_N && tag_vld[RL-1]) ? B_RD : '0;

    sdp_ram_rd_arb_rr_arb #(.NR(NR)) u_rr_arb (
        .Ck      (Ck),
        .Rst_N   (Rst_N),
        .en      (run),
        .req     (Rq_Vld),
        .gnt     (arb_gnt),
        .gnt_vld (arb_vld),
        .gnt_idx (arb_idx)
    );

    always_comb begin
        A_CE = 1'b0;
        A_WE = 1'b0;
        A_Ad = '0;
        A_WD = '0;
        if (Rst_N && state == ST_CLR) begin
            A_CE = 1'b1;
            A_WE = 1'b1;
            A_Ad = clr_cnt;
        end else if (run) begin
            A_CE = Wr_Vld;
            A_WE = Wr_Vld;
            A_Ad = Wr_Ad;
            A_WD = Wr_D;
        end
    end

    always_ff @(posedge Ck) begin
        if (!Rst_N) begin
            state   <= CLR_RST ? ST_CLR : ST_RUN;
            clr_cnt <= '0;
        end else begin
            case (state)
                ST_CLR: begin
                    clr_cnt <= clr_cnt + 1'b1;
                    if (clr_cnt == '1) state <= ST_RUN;
                end
                ST_RUN:   if (Clr_Req) state <= ST_DRAIN;
                ST_DRAIN: if (tag_vld == '0) state <= ST_CLR;
                default:  state <= ST_RUN;
            endcase
        end
    end

    // NOTE: only the valid bits of the tag pipe need reset; the index bits are ignored while invalid.
    always_ff @(posedge Ck) begin
        if (!Rst_N) begin
            tag_vld <= '0;
        end else begin
            tag_vld[0] <= arb_vld;
            for (int s = 1; s < RL; s++) tag_vld[s] <= tag_vld[s-1];
        end
    end

    always_ff @(posedge Ck) begin
        tag_idx[0] <= arb_idx;
        for (int s = 1; s < RL; s++) tag_idx[s] <= tag_idx[s-1];
    end

endmodule

// File: tb/tb_sdp_ram_rd_arb.sv
// Self-checking bench for sdp_ram_rd_arb with a registered-output RAM model and a
// queue-based reference of memory contents, round-robin order and response timing.
module tb_sdp_ram_rd_arb;

    localparam int AW    = 4;
    localparam int DW    = 8;
    localparam int NR    = 2;
    localparam int RL    = 2;
    localparam int DEPTH = 1 << AW;

    logic             Ck      = 1'b0;
    logic             Rst_N   = 1'b0;
    logic             Clr_Req = 1'b0;
    logic             Wr_Vld  = 1'b0;
    logic [AW-1:0]    Wr_Ad   = '0;
    logic [DW-1:0]    Wr_D    = '0;
    logic [NR-1:0]    Rq_Vld  = '0;
    logic [NR*AW-1:0] Rq_Ad   = '0;
    logic             Clr_Busy, Wr_Rdy, A_CE, A_WE, B_CE;
    logic [NR-1:0]    Rq_Rdy, Rs_Vld;
    logic [DW-1:0]    Rs_D, A_WD, B_RD;
    logic [AW-1:0]    A_Ad, B_Ad;

    sdp_ram_rd_arb #(.AW(AW), .DW(DW), .NR(NR), .OR("TRUE"), .CLR_RST(1'b1)) dut (
        .Ck(Ck), .Rst_N(Rst_N), .Clr_Req(Clr_Req), .Clr_Busy(Clr_Busy),
        .Wr_Vld(Wr_Vld), .Wr_Rdy(Wr_Rdy), .Wr_Ad(Wr_Ad), .Wr_D(Wr_D),
        .Rq_Vld(Rq_Vld), .Rq_Rdy(Rq_Rdy), .Rq_Ad(Rq_Ad),
        .Rs_Vld(Rs_Vld), .Rs_D(Rs_D),
        .A_CE(A_CE), .A_WE(A_WE), .A_Ad(A_Ad), .A_WD(A_WD),
        .B_CE(B_CE), .B_Ad(B_Ad), .B_RD(B_RD)
    );

    always #5 Ck = ~Ck;

    // RAM wrapper stand-in: write port A, read port B with array register plus output register.
    logic [DW-1:0] ram [DEPTH];
    logic [DW-1:0] ram_q;
    always @(posedge Ck) begin
        if (A_CE && A_WE) ram[A_Ad] <= A_WD;
        if (B_CE) ram_q <= ram[B_Ad];
        B_RD <= ram_q;
    end

    int cyc = 0;
    always @(posedge Ck) cyc <= cyc + 1;

    // Reference model state.
    typedef struct { int due; int idx; logic [DW-1:0] data; } rsp_t;
    rsp_t          exp_q[$];
    logic [DW-1:0] ref_mem [DEPTH];
    int            last_gnt = NR - 1;
    bit            model_run = 1'b0;
    int            errors = 0;
    int            checks = 0;

    function automatic int pick(input logic [NR-1:0] vld);
        for (int k = 1; k <= NR; k++) begin
            int i;
            i = (last_gnt + k) % NR;
            if (vld[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [NR-1:0] exp_rdy();
        logic [NR-1:0] r;
        int            g;
        r = '0;
        g = model_run ? pick(Rq_Vld) : -1;
        if (g >= 0) r[g] = 1'b1;
        return r;
    endfunction

    function automatic void expect_rsp(output logic [NR-1:0] v, output logic [DW-1:0] d);
        v = '0;
        d = '0;
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            v[exp_q[0].idx] = 1'b1;
            d = exp_q[0].data;
            exp_q.delete(0);
        end
    endfunction

    function automatic void zero_model();
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    endfunction

    task automatic drive(input logic wv, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                         input logic [NR-1:0] rv, input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                         input logic cr);
        Wr_Vld = wv; Wr_Ad = wa; Wr_D = wd;
        Rq_Vld = rv; Rq_Ad = {a1, a0}; Clr_Req = cr;
        #1;
    endtask

    task automatic advance();
        int g;
        g = model_run ? pick(Rq_Vld) : -1;
        if (g >= 0) begin
            exp_q.push_back('{cyc + RL, g, ref_mem[Rq_Ad[g*AW +: AW]]});
            last_gnt = g;
        end
        if (model_run && Wr_Vld) ref_mem[Wr_Ad] = Wr_D;
        @(posedge Ck);
        @(negedge Ck);
    endtask

    task automatic test_reset();
        logic [NR-1:0] ev;
        logic [DW-1:0] ed;
        Rst_N = 1'b0;
        model_run = 1'b0;
        last_gnt = NR - 1;
        exp_q.delete();
        drive(1'b1, 4'h3, 8'hAA, 2'b11, 4'h1, 4'h2, 1'b1);
        repeat (2) advance();
        checks++;
        if ({A_CE, A_WE, B_CE, Wr_Rdy, Clr_Busy, Rs_Vld, Rq_Rdy, A_Ad, B_Ad, A_WD, Rs_D} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got A_CE=%b A_WE=%b B_CE=%b Wr_Rdy=%b Clr_Busy=%b Rs_Vld=%b Rq_Rdy=%b A_Ad=%h B_Ad=%h A_WD=%h Rs_D=%h exp all 0",
                     A_CE, A_WE, B_CE, Wr_Rdy, Clr_Busy, Rs_Vld, Rq_Rdy, A_Ad, B_Ad, A_WD, Rs_D);
        end
        Rst_N = 1'b1;
        #1;
        for (int i = 0; i < DEPTH; i++) begin
            checks++;
            if (A_CE !== 1'b1 || A_WE !== 1'b1 || A_Ad !== AW'(i) || A_WD !== 8'h00 ||
                Clr_Busy !== 1'b1 || Wr_Rdy !== 1'b0 || Rq_Rdy !== 2'b00 || B_CE !== 1'b1) begin
                errors++;
                $display("FAIL clear_cycle_%0d got A_CE=%b A_WE=%b A_Ad=%0d A_WD=%h Clr_Busy=%b Wr_Rdy=%b Rq_Rdy=%b B_CE=%b exp 1 1 %0d 00 1 0 00 1",
                         i, A_CE, A_WE, A_Ad, A_WD, Clr_Busy, Wr_Rdy, Rq_Rdy, B_CE, i);
            end
            advance();
        end
        zero_model();
        model_run = 1'b1;
        drive(1'b0, '0, '0, 2'b00, '0, '0, 1'b0);
        checks++;
        if (Clr_Busy !== 1'b0 || Wr_Rdy !== 1'b1) begin
            errors++;
            $display("FAIL run_after_clear got Clr_Busy=%b Wr_Rdy=%b exp 0 1", Clr_Busy, Wr_Rdy);
        end
        for (int i = 0; i < DEPTH + RL; i++) begin
            if (i < DEPTH) drive(1'b0, '0, '0, (i % 2 == 0) ? 2'b01 : 2'b10, AW'(i), AW'(i), 1'b0);
            else           drive(1'b0, '0, '0, 2'b00, '0, '0, 1'b0);
            checks++;
            if (Rq_Rdy !== exp_rdy()) begin
                errors++;
                $display("FAIL clear_read_grant_%0d got=%b exp=%b", i, Rq_Rdy, exp_rdy());
            end
            expect_rsp(ev, ed);
            checks++;
            if (Rs_Vld !== ev || (ev != '0 && Rs_D !== 8'h00)) begin
                errors++;
                $display("FAIL clear_read_data_%0d got Rs_Vld=%b Rs_D=%h exp Rs_Vld=%b Rs_D=00", i, Rs_Vld, Rs_D, ev);
            end
            advance();
        end
    endtask

    task automatic test_write_read();
        logic [NR-1:0] ev;
        logic [DW-1:0] ed;
        drive(1'b1, 4'd5, 8'h3C, 2'b00, '0, '0, 1'b0);
        checks++;
        if (A_CE !== 1'b1 || A_WE !== 1'b1 || A_Ad !== 4'd5 || A_WD !== 8'h3C) begin
            errors++;
            $display("FAIL write_port got A_CE=%b A_WE=%b A_Ad=%0d A_WD=%h exp 1 1 5 3c", A_CE, A_WE, A_Ad, A_WD);
        end
        advance();
        drive(1'b0, '0, '0, 2'b10, '0, 4'd5, 1'b0);
        checks++;
        if (Rq_Rdy !== 2'b10 || B_Ad !== 4'd5) begin
            errors++;
            $display("FAIL wr_rd_grant got Rq_Rdy=%b B_Ad=%0d exp 10 5", Rq_Rdy, B_Ad);
        end
        advance();
        drive(1'b0, '0, '0, 2'b00, '0, '0, 1'b0);
        expect_rsp(ev, ed);
        checks++;
        if (Rs_Vld !== 2'b00 || ev !== 2'b00) begin
            errors++;
            $display("FAIL wr_rd_early got Rs_Vld=%b exp 00", Rs_Vld);
        end
        advance();
        expect_rsp(ev, ed);
        checks++;
        if (Rs_Vld !== 2'b10 || Rs_D !== 8'h3C || Rs_Vld !== ev || Rs_D !== ed) begin
            errors++;
            $display("FAIL wr_rd_response got Rs_Vld=%b Rs_D=%h exp 10 3c", Rs_Vld, Rs_D);
        end
        advance();
    endtask

    task automatic test_alternate();
        logic [NR-1:0] ev, eg, er;
        logic [DW-1:0] ed;
        for (int k = 0; k < 6 + RL; k++) begin
            if (k < 6) drive(1'b0, '0, '0, 2'b11, 4'($urandom), 4'($urandom), 1'b0);
            else       drive(1'b0, '0, '0, 2'b00, '0, '0, 1'b0);
            eg = (k < 6) ? ((k % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
            checks++;
            if (Rq_Rdy !== eg) begin
                errors++;
                $display("FAIL alt_grant_%0d got=%b exp=%b", k, Rq_Rdy, eg);
            end
            expect_rsp(ev, ed);
            er = (k >= RL) ? (((k - RL) % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
            checks++;
            if (Rs_Vld !== er || Rs_Vld !== ev || (ev != '0 && Rs_D !== ed)) begin
                errors++;
                $display("FAIL alt_response_%0d got Rs_Vld=%b Rs_D=%h exp Rs_Vld=%b Rs_D=%h", k, Rs_Vld, Rs_D, er, ed);
            end
            advance();
        end
    endtask

    task automatic test_clear_req();
        logic [NR-1:0] ev;
        logic [DW-1:0] ed;
        int            n;
        drive(1'b1, 4'd9, 8'h5A, 2'b00, '0, '0, 1'b0);
        advance();
        drive(1'b0, '0, '0, 2'b01, 4'd9, '0, 1'b0);
        checks++;
        if (Rq_Rdy !== 2'b01) begin
            errors++;
            $display("FAIL clr_pre_grant got=%b exp=01", Rq_Rdy);
        end
        advance();
        drive(1'b0, '0, '0, 2'b00, '0, '0, 1'b1);
        expect_rsp(ev, ed);
        checks++;
        if (Rs_Vld !== ev || Clr_Busy !== 1'b0) begin
            errors++;
            $display("FAIL clr_req_cycle got Rs_Vld=%b Clr_Busy=%b exp %b 0", Rs_Vld, Clr_Busy, ev);
        end
        advance();
        model_run = 1'b0;
        drive(1'b0, '0, '0, 2'b11, 4'd9, 4'd9, 1'b0);
        expect_rsp(ev, ed);
        checks++;
        if (Rs_Vld !== 2'b01 || Rs_D !== 8'h5A || Rs_Vld !== ev || Clr_Busy !== 1'b1 || Rq_Rdy !== 2'b00) begin
            errors++;
            $display("FAIL drain_response got Rs_Vld=%b Rs_D=%h Clr_Busy=%b Rq_Rdy=%b exp 01 5a 1 00",
                     Rs_Vld, Rs_D, Clr_Busy, Rq_Rdy);
        end
        advance();
        n = 0;
        while (!(A_WE === 1'b1 && A_Ad === 4'd0) && n < RL + 2) begin
            checks++;
            if (Clr_Busy !== 1'b1 || Rq_Rdy !== 2'b00 || Rs_Vld !== 2'b00 || A_WE !== 1'b0) begin
                errors++;
                $display("FAIL drain_idle got Clr_Busy=%b Rq_Rdy=%b Rs_Vld=%b A_WE=%b exp 1 00 00 0",
                         Clr_Busy, Rq_Rdy, Rs_Vld, A_WE);
            end
            advance();
            n++;
        end
        checks++;
        if (!(A_WE === 1'b1 && A_Ad === 4'd0)) begin
            errors++;
            $display("FAIL clear_start_timeout got A_WE=%b A_Ad=%0d exp 1 0 within %0d cycles", A_WE, A_Ad, RL + 2);
        end
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b0, '0, '0, 2'b11, 4'd9, 4'd9, (i == 3) ? 1'b1 : 1'b0);
            checks++;
            if (A_WE !== 1'b1 || A_Ad !== AW'(i) || A_WD !== 8'h00 || Clr_Busy !== 1'b1 || Rq_Rdy !== 2'b00) begin
                errors++;
                $display("FAIL reclear_%0d got A_WE=%b A_Ad=%0d A_WD=%h Clr_Busy=%b Rq_Rdy=%b exp 1 %0d 00 1 00",
                         i, A_WE, A_Ad, A_WD, Clr_Busy, Rq_Rdy, i);
            end
            advance();
        end
        zero_model();
        model_run = 1'b1;
        drive(1'b0, '0, '0, 2'b11, 4'd9, 4'd9, 1'b0);
        checks++;
        if (Clr_Busy !== 1'b0 || Rq_Rdy !== exp_rdy()) begin
            errors++;
            $display("FAIL post_clear_grant got Clr_Busy=%b Rq_Rdy=%b exp 0 %b", Clr_Busy, Rq_Rdy, exp_rdy());
        end
        advance();
        drive(1'b0, '0, '0, 2'b00, '0, '0, 1'b0);
        for (int k = 1; k <= RL; k++) begin
            expect_rsp(ev, ed);
            checks++;
            if (Rs_Vld !== ev || (ev != '0 && Rs_D !== 8'h00)) begin
                errors++;
                $display("FAIL post_clear_read_%0d got Rs_Vld=%b Rs_D=%h exp Rs_Vld=%b Rs_D=00", k, Rs_Vld, Rs_D, ev);
            end
            advance();
        end
    endtask

    task automatic test_reset_mid();
        drive(1'b0, '0, '0, 2'b01, 4'd2, '0, 1'b0);
        checks++;
        if (Rq_Rdy !== exp_rdy()) begin
            errors++;
            $display("FAIL rst_mid_grant got=%b exp=%b", Rq_Rdy, exp_rdy());
        end
        advance();
        Rst_N = 1'b0;
        exp_q.delete();
        model_run = 1'b0;
        last_gnt = NR - 1;
        drive(1'b1, 4'd4, 8'h77, 2'b11, 4'd1, 4'd2, 1'b0);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if ({A_CE, A_WE, B_CE, Wr_Rdy, Clr_Busy, Rs_Vld, Rq_Rdy, A_Ad, B_Ad, Rs_D} !== '0) begin
                errors++;
                $display("FAIL rst_mid_outputs_%0d got A_CE=%b B_CE=%b Wr_Rdy=%b Clr_Busy=%b Rs_Vld=%b Rq_Rdy=%b exp all 0",
                         k, A_CE, B_CE, Wr_Rdy, Clr_Busy, Rs_Vld, Rq_Rdy);
            end
            advance();
        end
        Rst_N = 1'b1;
        drive(1'b0, '0, '0, 2'b00, '0, '0, 1'b0);
        for (int i = 0; i <= DEPTH; i++) begin
            checks++;
            if (Rs_Vld !== 2'b00 || Clr_Busy !== (i < DEPTH) || (i < DEPTH && A_Ad !== AW'(i))) begin
                errors++;
                $display("FAIL rst_mid_reclear_%0d got Rs_Vld=%b Clr_Busy=%b A_Ad=%0d exp 00 %b %0d",
                         i, Rs_Vld, Clr_Busy, A_Ad, (i < DEPTH), i);
            end
            if (i < DEPTH) advance();
        end
        zero_model();
        model_run = 1'b1;
    endtask

    task automatic test_same_addr();
        logic [NR-1:0] ev;
        logic [DW-1:0] ed;
        drive(1'b1, 4'd7, 8'h11, 2'b00, '0, '0, 1'b0);
        advance();
        drive(1'b1, 4'd7, 8'h22, 2'b01, 4'd7, '0, 1'b0);
        checks++;
        if (Rq_Rdy !== 2'b01 || A_WE !== 1'b1 || B_Ad !== 4'd7) begin
            errors++;
            $display("FAIL same_addr_grant got Rq_Rdy=%b A_WE=%b B_Ad=%0d exp 01 1 7", Rq_Rdy, A_WE, B_Ad);
        end
        advance();
        drive(1'b0, '0, '0, 2'b10, '0, 4'd7, 1'b0);
        checks++;
        if (Rq_Rdy !== 2'b10) begin
            errors++;
            $display("FAIL same_addr_reread_grant got=%b exp=10", Rq_Rdy);
        end
        advance();
        drive(1'b0, '0, '0, 2'b00, '0, '0, 1'b0);
        expect_rsp(ev, ed);
        checks++;
        if (Rs_Vld !== 2'b01 || Rs_D !== 8'h11 || Rs_D !== ed) begin
            errors++;
            $display("FAIL same_addr_old got Rs_Vld=%b Rs_D=%h exp 01 11", Rs_Vld, Rs_D);
        end
        advance();
        expect_rsp(ev, ed);
        checks++;
        if (Rs_Vld !== 2'b10 || Rs_D !== 8'h22 || Rs_D !== ed) begin
            errors++;
            $display("FAIL same_addr_new got Rs_Vld=%b Rs_D=%h exp 10 22", Rs_Vld, Rs_D);
        end
        advance();
    endtask

    task automatic test_random();
        logic [NR-1:0] ev, eg;
        logic [DW-1:0] ed;
        int            g;
        for (int n = 0; n < 400 + RL; n++) begin
            if (n < 400) drive(1'($urandom), 4'($urandom), 8'($urandom), 2'($urandom),
                               4'($urandom), 4'($urandom), 1'b0);
            else         drive(1'b0, '0, '0, 2'b00, '0, '0, 1'b0);
            eg = exp_rdy();
            g  = pick(Rq_Vld);
            checks++;
            if (Rq_Rdy !== eg || (g >= 0 && B_Ad !== Rq_Ad[g*AW +: AW]) || A_WE !== Wr_Vld) begin
                errors++;
                $display("FAIL rand_grant_%0d got Rq_Rdy=%b B_Ad=%0d A_WE=%b exp Rq_Rdy=%b A_WE=%b",
                         n, Rq_Rdy, B_Ad, A_WE, eg, Wr_Vld);
            end
            expect_rsp(ev, ed);
            checks++;
            if (Rs_Vld !== ev || (ev != '0 && Rs_D !== ed)) begin
                errors++;
                $display("FAIL rand_response_%0d got Rs_Vld=%b Rs_D=%h exp Rs_Vld=%b Rs_D=%h", n, Rs_Vld, Rs_D, ev, ed);
            end
            advance();
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL rand_leftover got %0d pending exp 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_alternate();
        test_clear_req();
        test_reset_mid();
        test_same_addr();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
